// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatting and writeback
// source selection. Presents a registered register-file write port that also
// serves as a forwarding source for the hazard logic.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall              hold every WB register
//   flush              insert a bubble on the next edge
//   m_*                MEM-stage instruction fields, load data, link value
//   wb_valid           registered valid
//   wb_reg_write       register-file write enable (never for x0 or misaligned)
//   wb_rd, wb_data     register-file write index / data
//   wb_misalign        load-address-misaligned flag of the retiring instruction
//   retire_cnt         64-bit retired-instruction counter (MEMWB_RETIRE_CNT_EN only)
//
// Optional feature: define MEMWB_RETIRE_CNT_EN to add the retire_cnt output.
module mem_wb_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  m_valid,
    input  logic                  m_reg_write,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic [1:0]            m_wb_sel,
    input  logic                  m_mem_read,
    input  logic [2:0]            m_funct3,
    input  logic [XLEN-1:0]       m_alu_result,
    input  logic [XLEN-1:0]       m_read_data,
    input  logic [XLEN-1:0]       m_pc_plus4,
`ifdef MEMWB_RETIRE_CNT_EN
    output logic [63:0]           retire_cnt,
`endif
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_misalign
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [1:0]            off;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [XLEN-1:0]       load_data;
    logic                  f3_undef;
    logic                  misalign;
    logic [XLEN-1:0]       src_data;

    logic                  valid_d,     valid_q;
    logic                  reg_write_d, reg_write_q;
    logic [REG_ADDR_W-1:0] rd_d,        rd_q;
    logic [XLEN-1:0]       data_d,      data_q;
    logic                  misalign_d,  misalign_q;

    // Lane extraction and extension of the raw memory word
    always_comb begin
        off       = m_alu_result[1:0];
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        load_data = m_read_data;
        f3_undef  = 1'b0;

        case (off)
            2'd0:    byte_lane = m_read_data[7:0];
            2'd1:    byte_lane = m_read_data[15:8];
            2'd2:    byte_lane = m_read_data[23:16];
            default: byte_lane = m_read_data[31:24];
        endcase
        half_lane = off[1] ? m_read_data[31:16] : m_read_data[15:0];

        case (m_funct3)
            F3_LB:   load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_lane};
            F3_LW:   load_data = m_read_data;
            default: begin
                load_data = m_read_data;
                f3_undef  = 1'b1;
            end
        endcase
    end

    // Misalignment detection and writeback source select
    always_comb begin
        misalign = 1'b0;
        src_data = m_alu_result;

        if (m_valid && m_mem_read) begin
            misalign = f3_undef
                     | (((m_funct3 == F3_LH) || (m_funct3 == F3_LHU)) & off[0])
                     | ((m_funct3 == F3_LW) & (off != 2'd0));
        end

        case (m_wb_sel)
            SEL_LOAD: src_data = load_data;
            SEL_PC4:  src_data = m_pc_plus4;
            default:  src_data = m_alu_result;
        endcase
    end

    // Next-state for the WB registers; flush forces a zeroed bubble
    always_comb begin
        valid_d     = m_valid;
        reg_write_d = m_valid & m_reg_write & (m_rd != '0) & ~misalign;
        rd_d        = m_rd;
        data_d      = src_data;
        misalign_d  = misalign;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            data_d      = '0;
            misalign_d  = 1'b0;
        end
    end

    // WB register bank: rst > stall > (flush folded into _d) > load
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
        end else if (!stall) begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            misalign_q  <= misalign_d;
        end
    end

    assign wb_valid     = valid_q;
    assign wb_reg_write = reg_write_q;
    assign wb_rd        = rd_q;
    assign wb_data      = data_q;
    assign wb_misalign  = misalign_q;

`ifdef MEMWB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_d, retire_cnt_q;

    // Counts every instruction leaving the stage, misaligned loads included
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (!stall && !flush && m_valid) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback formatting, directly downstream of the data-memory stage.
- Captures the raw 32-bit word returned by the memory stage and lane-selects/extends it per the load funct3.
- Selects the writeback source and presents a registered register-file write port.
- Same-cycle register-file write and forwarding source for the hazard logic; supports stall, flush and misaligned-load detection.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold all WB registers at current values.
- flush  input  1  insert a bubble (valid cleared) on the next edge.
- m_valid  input  1  MEM-stage instruction is valid.
- m_reg_write  input  1  instruction writes rd.
- m_rd  input  REG_ADDR_W  destination register.
- m_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- m_mem_read  input  1  instruction is a load.
- m_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- m_alu_result  input  XLEN  ALU result; also the byte address for loads.
- m_read_data  input  XLEN  word from the memory stage containing the addressed byte.
- m_pc_plus4  input  XLEN  link value.
- wb_valid  output  1  registered valid.
- wb_reg_write  output  1  register-file write enable.
- wb_rd  output  REG_ADDR_W  register-file write index.
- wb_data  output  XLEN  register-file write data.
- wb_misalign  output  1  load-address-misaligned flag for the retiring instruction.

Behaviour:
- Latency: one cycle. Values presented on m_* at edge N appear on wb_* after edge N.
- Update priority each edge: rst > stall > flush > normal load.
- Reset values:
  - wb_valid = 0, wb_reg_write = 0, wb_misalign = 0.
  - wb_rd = 0, wb_data = 0.
- Stall: every output register holds. stall has priority over flush, so a flush asserted during a stall is lost; the hazard unit must re-assert it.
- Flush (no stall): wb_valid, wb_reg_write and wb_misalign go to 0. wb_rd and wb_data go to 0.
- Load formatting (combinational, before the register):
  - off = m_alu_result[1:0].
  - LB/LBU: byte lane off, i.e. bits [8*off+7 : 8*off]; sign- or zero-extend.
  - LH/LHU: half lane off[1], i.e. bits [16*off[1]+15 : 16*off[1]]; sign- or zero-extend.
  - LW: whole word.
  - Undefined funct3 (011, 110, 111): whole word, and treated as misaligned.
- Misalignment:
  - misalign = m_valid & m_mem_read & ((LH/LHU & off[0]) | (LW & off != 0) | undefined funct3).
  - Registered into wb_misalign. The write is suppressed, but wb_valid stays 1.
- Source select:
  - wb_sel 01 = formatted load data.
  - wb_sel 10 = m_pc_plus4.
  - wb_sel 00 or 11 = m_alu_result.
- Write enable: wb_reg_write = m_valid & m_reg_write & (m_rd != 0) & ~misalign, registered. Writes to x0 are never issued.
- When m_valid = 0 (no stall/flush): wb_valid = 0, wb_reg_write = 0, wb_misalign = 0; wb_rd and wb_data still load (don't-care).
- Reset mid-stall: reset wins; all outputs return to reset values on that edge.
- No combinational path from any m_* input to any wb_* output.

Optional Feature:
- Macro: MEMWB_RETIRE_CNT_EN.
- When defined, add output retire_cnt (64 bits).
  - Reset to 0.
  - Increments by 1 on each edge where stall = 0, flush = 0 and m_valid = 1 (misaligned loads included).
  - Holds otherwise; wraps from all-ones to 0.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with m_valid = 1 -> all wb_* = 0; deassert -> the next edge loads normally.
- Load extension: m_read_data = 0x8034_F2A1, wb_sel = 01, m_rd = 5:
  - LB, addr 0x100 -> wb_data 0xFFFF_FFA1.
  - LBU, addr 0x101 -> 0x0000_00F2.
  - LH, addr 0x102 -> 0xFFFF_8034.
  - LHU, addr 0x100 -> 0x0000_F2A1.
  - LW -> 0x8034_F2A1.
  - Each result has wb_reg_write = 1.
- Misalign: LW at addr 0x102 and LH at 0x101 -> wb_misalign = 1, wb_reg_write = 0, wb_valid = 1. LB at 0x103 -> wb_misalign = 0.
- Source / x0: wb_sel = 10, m_pc_plus4 = 0x0000_0044, rd = 1 -> wb_data 0x44. Same instruction with rd = 0 -> wb_reg_write = 0.
- Stall/flush:
  - Load A (ALU 0x11), then hold stall for 3 cycles while presenting B -> outputs stay A.
  - Release stall -> B appears.
  - flush with stall = 1 -> no change.
  - flush with stall = 0 -> wb_valid = 0 next edge.
- With MEMWB_RETIRE_CNT_EN: 10 valid, 2 flushed and 3 stalled cycles -> retire_cnt = 10. Preload all-ones (force) plus one valid -> 0.
